// File: rtl/usc_rv_int_rf_wb_if.sv
// Bundle of allocation, writeback handshake and register-file read-side signals.
// master drives requests; slave is the register file itself.
interface usc_rv_int_rf_wb_if #(
   parameter int XLEN = 32,
   parameter int NREG = 32
);
   logic                   alloc_vld;
   logic [4:0]             alloc_atag;

   logic                   wb0_vld;
   logic [4:0]             wb0_atag;
   logic [XLEN-1:0]        wb0_data;
   logic                   wb0_rdy;

   logic                   wb1_vld;
   logic [4:0]             wb1_atag;
   logic [XLEN-1:0]        wb1_data;
   logic                   wb1_rdy;

   logic                   wb2_vld;
   logic [4:0]             wb2_atag;
   logic [XLEN-1:0]        wb2_data;
   logic                   wb2_rdy;

   logic [NREG*XLEN-1:0]   rf_entry_flat;
   logic [NREG-1:0]        busy;

   modport master (
      output alloc_vld, alloc_atag,
      output wb0_vld, wb0_atag, wb0_data,
      output wb1_vld, wb1_atag, wb1_data,
      output wb2_vld, wb2_atag, wb2_data,
      input  wb0_rdy, wb1_rdy, wb2_rdy,
      input  rf_entry_flat, busy
   );

   modport slave (
      input  alloc_vld, alloc_atag,
      input  wb0_vld, wb0_atag, wb0_data,
      input  wb1_vld, wb1_atag, wb1_data,
      input  wb2_vld, wb2_atag, wb2_data,
      output wb0_rdy, wb1_rdy, wb2_rdy,
      output rf_entry_flat, busy
   );
endinterface

// File: rtl/usc_rv_int_rf_wb.sv
// Integer register file with two write ports: wb0 owns one, wb1/wb2 share the
// other through a round-robin arbiter; also keeps the pending-write scoreboard.
module usc_rv_int_rf_wb #(
   parameter int XLEN = 32,
   parameter int NREG = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   usc_rv_int_rf_wb_if.slave    bus
);
   localparam int AW = 5;

   typedef enum logic {
      PickWb1 = 1'b0,
      PickWb2 = 1'b1
   } rrSel_e;

   rrSel_e            rrPtr_q, rrPtr_d;
   logic [XLEN-1:0]   entry_q [NREG];
   logic [XLEN-1:0]   entry_d [NREG];
   logic [NREG-1:0]   busy_q, busy_d;

   logic              grant1, grant2;
   logic              portBVld;
   logic [AW-1:0]     portBAtag;
   logic [XLEN-1:0]   portBData;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rrPtr_q <= PickWb1;
         busy_q  <= '0;
         for (int i = 0; i < NREG; i++) begin
            entry_q[i] <= '0;
         end
      end else begin
         rrPtr_q <= rrPtr_d;
         busy_q  <= busy_d;
         for (int i = 0; i < NREG; i++) begin
            entry_q[i] <= entry_d[i];
         end
      end
   end

   // The pointer only moves on a real conflict, so a lone requester never steals a turn.
   always_comb begin
      rrPtr_d = rrPtr_q;
      if (bus.wb1_vld && bus.wb2_vld) begin
         rrPtr_d = (rrPtr_q == PickWb1) ? PickWb2 : PickWb1;
      end
   end

   always_comb begin
      grant1 = 1'b0;
      grant2 = 1'b0;
      if (!reset) begin
         if (bus.wb1_vld && bus.wb2_vld) begin
            grant1 = (rrPtr_q == PickWb1);
            grant2 = (rrPtr_q == PickWb2);
         end else begin
            grant1 = bus.wb1_vld;
            grant2 = bus.wb2_vld;
         end
      end
   end

   assign bus.wb0_rdy = !reset;
   assign bus.wb1_rdy = grant1;
   assign bus.wb2_rdy = grant2;

   assign portBVld  = grant1 || grant2;
   assign portBAtag = grant1 ? bus.wb1_atag : bus.wb2_atag;
   assign portBData = grant1 ? bus.wb1_data : bus.wb2_data;

   // wb0 is applied last so it overrides the shared port on a same-register collision.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         entry_d[i] = entry_q[i];
         if (portBVld && (portBAtag == AW'(i))) begin
            entry_d[i] = portBData;
         end
         if (bus.wb0_vld && (bus.wb0_atag == AW'(i))) begin
            entry_d[i] = bus.wb0_data;
         end
      end
      entry_d[0] = '0;
   end

   // Clears come before the set so a same-cycle allocation keeps the register pending.
   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NREG; i++) begin
         if (portBVld && (portBAtag == AW'(i))) begin
            busy_d[i] = 1'b0;
         end
         if (bus.wb0_vld && (bus.wb0_atag == AW'(i))) begin
            busy_d[i] = 1'b0;
         end
         if (bus.alloc_vld && (bus.alloc_atag == AW'(i))) begin
            busy_d[i] = 1'b1;
         end
      end
      busy_d[0] = 1'b0;
   end

   always_comb begin
      bus.rf_entry_flat = '0;
      for (int i = 0; i < NREG; i++) begin
         bus.rf_entry_flat[i*XLEN +: XLEN] = entry_q[i];
      end
   end

   assign bus.busy = busy_q;

endmodule

// File: tb/tb_usc_rv_int_rf_wb.sv
// Randomised bench for usc_rv_int_rf_wb: directed scenarios followed by random
// traffic, all checked against an array-based register-file model.
module tb_usc_rv_int_rf_wb;
   localparam int XLEN = 32;
   localparam int NREG = 32;

   logic clk;
   logic reset;

   usc_rv_int_rf_wb_if #(.XLEN(XLEN), .NREG(NREG)) bus ();

   usc_rv_int_rf_wb #(.XLEN(XLEN), .NREG(NREG)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int totalCount = 0;
   int badCount   = 0;

   logic [XLEN-1:0] mRf [NREG];
   logic [NREG-1:0] mBusy;
   bit              mTurn2;
   logic            obsRdy0, obsRdy1, obsRdy2;
   bit              expG1, expG2;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      totalCount++;
      if (observed !== expected) begin
         badCount++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelClear();
      for (int i = 0; i < NREG; i++) mRf[i] = '0;
      mBusy  = '0;
      mTurn2 = 1'b0;
   endtask

   task automatic checkState();
      for (int i = 0; i < NREG; i++) begin
         checkOutput($sformatf("entry%0d", i), bus.rf_entry_flat[i*XLEN +: XLEN], mRf[i]);
      end
      checkOutput("busy", bus.busy, mBusy);
   endtask

   // Called at posedge+1: drives one cycle, checks grants at the falling edge,
   // advances the model, then checks register state just after the next edge.
   task automatic applyStimulus(
      input logic av,  input logic [4:0] aa,
      input logic w0v, input logic [4:0] w0a, input logic [31:0] w0d,
      input logic w1v, input logic [4:0] w1a, input logic [31:0] w1d,
      input logic w2v, input logic [4:0] w2a, input logic [31:0] w2d);
      bus.alloc_vld = av;  bus.alloc_atag = aa;
      bus.wb0_vld = w0v;   bus.wb0_atag = w0a;   bus.wb0_data = w0d;
      bus.wb1_vld = w1v;   bus.wb1_atag = w1a;   bus.wb1_data = w1d;
      bus.wb2_vld = w2v;   bus.wb2_atag = w2a;   bus.wb2_data = w2d;
      #4;
      expG1 = w1v && (!w2v || !mTurn2);
      expG2 = w2v && (!w1v || mTurn2);
      obsRdy0 = bus.wb0_rdy;
      obsRdy1 = bus.wb1_rdy;
      obsRdy2 = bus.wb2_rdy;
      checkOutput("wb0_rdy", {31'b0, obsRdy0}, 32'd1);
      checkOutput("wb1_rdy", {31'b0, obsRdy1}, {31'b0, expG1});
      checkOutput("wb2_rdy", {31'b0, obsRdy2}, {31'b0, expG2});
      if (w1v && w2v) mTurn2 = !mTurn2;
      if (expG1) begin
         if (w1a != 0) mRf[w1a] = w1d;
         mBusy[w1a] = 1'b0;
      end
      if (expG2) begin
         if (w2a != 0) mRf[w2a] = w2d;
         mBusy[w2a] = 1'b0;
      end
      if (w0v) begin
         if (w0a != 0) mRf[w0a] = w0d;
         mBusy[w0a] = 1'b0;
      end
      if (av && aa != 0) mBusy[aa] = 1'b1;
      @(posedge clk);
      #1;
      checkState();
   endtask

   // Called at posedge+1: asserts reset with live requests, checks it is
   // immediate and holds across an edge, then releases it.
   task automatic applyReset();
      bus.alloc_vld = 1'b1; bus.alloc_atag = 5'd3;
      bus.wb0_vld = 1'b1;   bus.wb0_atag = 5'd3; bus.wb0_data = 32'h1234;
      bus.wb1_vld = 1'b1;   bus.wb1_atag = 5'd4; bus.wb1_data = 32'h5678;
      bus.wb2_vld = 1'b1;   bus.wb2_atag = 5'd5; bus.wb2_data = 32'h9abc;
      reset = 1'b1;
      modelClear();
      #1;
      checkOutput("rst_wb0_rdy", {31'b0, bus.wb0_rdy}, 32'd0);
      checkOutput("rst_wb1_rdy", {31'b0, bus.wb1_rdy}, 32'd0);
      checkOutput("rst_wb2_rdy", {31'b0, bus.wb2_rdy}, 32'd0);
      checkState();
      @(posedge clk);
      #1;
      checkState();
      reset = 1'b0;
      bus.alloc_vld = 1'b0;
      bus.wb0_vld = 1'b0;
      bus.wb1_vld = 1'b0;
      bus.wb2_vld = 1'b0;
   endtask

   initial begin
      logic        p1, p2;
      logic [4:0]  a1, a2;
      logic [31:0] d1, d2;

      reset = 1'b1;
      bus.alloc_vld = 1'b0; bus.alloc_atag = '0;
      bus.wb0_vld = 1'b0;   bus.wb0_atag = '0; bus.wb0_data = '0;
      bus.wb1_vld = 1'b0;   bus.wb1_atag = '0; bus.wb1_data = '0;
      bus.wb2_vld = 1'b0;   bus.wb2_atag = '0; bus.wb2_data = '0;
      modelClear();
      @(posedge clk);
      #1;
      applyReset();

      // Allocate x5, then write it from wb0.
      applyStimulus(1, 5'd5, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      checkOutput("alloc_busy5", {31'b0, bus.busy[5]}, 32'd1);
      applyStimulus(0, 0, 1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
      checkOutput("wb_busy5", {31'b0, bus.busy[5]}, 32'd0);
      checkOutput("entry5", bus.rf_entry_flat[5*XLEN +: XLEN], 32'hDEADBEEF);

      // wb1 and wb2 both waiting from reset: wb1 first, wb2 next cycle.
      applyReset();
      applyStimulus(0, 0, 0, 0, 0, 1, 5'd3, 32'h11, 1, 5'd4, 32'h22);
      checkOutput("first_wb1", {31'b0, obsRdy1}, 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd4, 32'h22);
      checkOutput("second_wb2", {31'b0, obsRdy2}, 32'd1);
      checkOutput("entry3", bus.rf_entry_flat[3*XLEN +: XLEN], 32'h11);
      checkOutput("entry4", bus.rf_entry_flat[4*XLEN +: XLEN], 32'h22);

      // Continuous contention alternates, wb0 granted alongside.
      applyReset();
      for (int k = 0; k < 6; k++) begin
         applyStimulus(0, 0, 1, 5'(10 + k), 32'(k), 1, 5'd20, 32'(100 + k), 1, 5'd21, 32'(200 + k));
         checkOutput($sformatf("alt_wb1_%0d", k), {31'b0, obsRdy1}, {31'b0, (k % 2) == 0});
         checkOutput($sformatf("alt_wb2_%0d", k), {31'b0, obsRdy2}, {31'b0, (k % 2) == 1});
      end

      // Same-register collision: wb0 wins.
      applyStimulus(0, 0, 1, 5'd7, 32'hA, 1, 5'd7, 32'hB, 0, 0, 0);
      checkOutput("coll_rdy1", {31'b0, obsRdy1}, 32'd1);
      checkOutput("entry7", bus.rf_entry_flat[7*XLEN +: XLEN], 32'hA);
      checkOutput("busy7", {31'b0, bus.busy[7]}, 32'd0);

      // x0 is hardwired to zero and never pending.
      applyStimulus(1, 5'd0, 0, 0, 0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF);
      checkOutput("x0_rdy2", {31'b0, obsRdy2}, 32'd1);
      checkOutput("entry0", bus.rf_entry_flat[XLEN-1:0], 32'd0);
      checkOutput("busy0", {31'b0, bus.busy[0]}, 32'd0);

      // Allocation beats same-cycle write on busy, then async reset clears everything.
      applyStimulus(1, 5'd9, 1, 5'd9, 32'h55, 0, 0, 0, 0, 0, 0);
      checkOutput("busy9", {31'b0, bus.busy[9]}, 32'd1);
      checkOutput("entry9", bus.rf_entry_flat[9*XLEN +: XLEN], 32'h55);
      applyReset();

      // Random traffic; a stalled wb1/wb2 request is held until granted.
      p1 = 1'b0; p2 = 1'b0;
      a1 = '0; a2 = '0; d1 = '0; d2 = '0;
      for (int n = 0; n < 300; n++) begin
         if (!p1) begin
            p1 = ($urandom_range(0, 2) != 0);
            a1 = 5'($urandom_range(0, 7));
            d1 = $urandom;
         end
         if (!p2) begin
            p2 = ($urandom_range(0, 2) != 0);
            a2 = 5'($urandom_range(0, 7));
            d2 = $urandom;
         end
         applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                       p1, a1, d1, p2, a2, d2);
         if (expG1) p1 = 1'b0;
         if (expG2) p2 = 1'b0;
         if (n == 150) applyReset();
      end

      $display("test done: total=%0d bad=%0d", totalCount, badCount);
      $finish;
   end

endmodule
